// File: rtl/fanctrl_cfg_loader_pkg.sv
// Shared definitions for the fan controller configuration loader: register
// addresses, frame lengths and FSM/mode encodings.
package fanctrl_cfg_loader_pkg;

  localparam logic [3:0] ADDR_A0     = 4'd0;
  localparam logic [3:0] ADDR_A1     = 4'd1;
  localparam logic [3:0] ADDR_B0     = 4'd2;
  localparam logic [3:0] ADDR_B1     = 4'd3;
  localparam logic [3:0] ADDR_B2     = 4'd4;
  localparam logic [3:0] ADDR_PERIOD = 4'd5;
  localparam logic [3:0] ADDR_MIN    = 4'd6;
  localparam logic [3:0] ADDR_LAST   = 4'd6;

  localparam int unsigned NUM_COEF       = 5;
  localparam int unsigned PERIOD_NIBBLES = 3;
  localparam int unsigned MIN_NIBBLES    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } cfg_state_e;

  typedef enum logic {
    MODE_RUN    = 1'b0,
    MODE_CONFIG = 1'b1
  } cfg_mode_e;

  // Payload length in nibbles for a (valid) register address.
  function automatic int unsigned frame_nibbles(input logic [3:0] addr,
                                                input int unsigned coef_nibbles);
    if (addr == ADDR_PERIOD) return PERIOD_NIBBLES;
    if (addr == ADDR_MIN)    return MIN_NIBBLES;
    return coef_nibbles;
  endfunction

endpackage

// File: rtl/fanctrl_cfg_loader_shifter.sv
// Payload assembler: MSB-first nibble shift register with a nibble down-counter
// that flags the final nibble of a frame.
module cfg_nibble_shifter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              load,
  input  logic              shift,
  input  logic [CNT_W-1:0]  count_init,
  input  logic [3:0]        nibble,
  output logic [DATA_W-1:0] value_c,
  output logic              last_c
);

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      data_q  <= '0;
      count_q <= count_init;
    end else if (shift) begin
      data_q  <= value_c;
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Value including the nibble presented this cycle, so the last strobe can commit directly.
  assign value_c = DATA_W'({data_q, nibble});
  assign last_c  = (count_q == '0);

endmodule

// File: rtl/fanctrl_cfg_loader.sv
// Nibble-serial configuration loader: stages framed writes in shadow registers
// and applies them atomically to the PID/PWM active registers on window exit.
module fanctrl_cfg_loader
  import fanctrl_cfg_loader_pkg::*;
#(
  parameter int unsigned REG_BITWIDTH = 32,
  parameter int unsigned ADC_BITWIDTH = 8,
  parameter int unsigned PERIOD_RST   = 399,
  parameter int unsigned MIN_RST      = 0
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    config_en_i,
  input  logic                    strb_i,
  input  logic [3:0]              data_i,
  output logic [REG_BITWIDTH-1:0] a0_o,
  output logic [REG_BITWIDTH-1:0] a1_o,
  output logic [REG_BITWIDTH-1:0] b0_o,
  output logic [REG_BITWIDTH-1:0] b1_o,
  output logic [REG_BITWIDTH-1:0] b2_o,
  output logic [ADC_BITWIDTH:0]   pwm_period_o,
  output logic [ADC_BITWIDTH-1:0] pwm_min_o,
  output logic                    busy_o,
  output logic                    applied_o,
  output logic                    err_o
);

  localparam int unsigned COEF_NIBBLES = REG_BITWIDTH / 4;
  localparam int unsigned MAX_NIBBLES  = (COEF_NIBBLES > PERIOD_NIBBLES) ? COEF_NIBBLES
                                                                         : PERIOD_NIBBLES;
  localparam int unsigned CNT_W        = $clog2(MAX_NIBBLES);
  localparam int unsigned SR_W         = 4 * MAX_NIBBLES;
  localparam int unsigned PERIOD_W     = ADC_BITWIDTH + 1;
  localparam int unsigned MIN_W        = ADC_BITWIDTH;

  cfg_state_e state, state_next;
  logic       config_en_q;
  logic [2:0] addr_q;
  logic       rise_c, exit_c;
  logic       load, shift, shadow_we, apply, err_set;
  logic       err_q, applied_q, busy_q;

  logic [CNT_W-1:0] count_init;
  logic [SR_W-1:0]  value_c;
  logic             last_c;

  logic [REG_BITWIDTH-1:0] shadow_coef [NUM_COEF];
  logic [REG_BITWIDTH-1:0] active_coef [NUM_COEF];
  logic [PERIOD_W-1:0]     shadow_period, period_q;
  logic [MIN_W-1:0]        shadow_min, min_q;

  assign rise_c     = config_en_i & ~config_en_q;
  assign exit_c     = ~config_en_i & config_en_q;
  assign count_init = CNT_W'(frame_nibbles(data_i, COEF_NIBBLES) - 1);

  cfg_nibble_shifter #(
    .DATA_W (SR_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load       (load),
    .shift      (shift),
    .count_init (count_init),
    .nibble     (data_i),
    .value_c    (value_c),
    .last_c     (last_c)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      config_en_q <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      applied_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      config_en_q <= config_en_i;
      applied_q   <= apply;
      busy_q      <= (state_next == PAYLOAD);
      if (load) addr_q <= data_i[2:0];
      if (rise_c)       err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  // Window exit is decided before any strobe, so an exit-cycle strobe is dropped.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    shadow_we  = 1'b0;
    apply      = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (rise_c) state_next = ADDR;
      end
      ADDR: begin
        if (exit_c) begin
          apply      = ~err_q;
          state_next = IDLE;
        end else if (strb_i) begin
          if (data_i <= ADDR_LAST) begin
            load       = 1'b1;
            state_next = PAYLOAD;
          end else begin
            err_set    = 1'b1;
            state_next = DISCARD;
          end
        end
      end
      PAYLOAD: begin
        if (exit_c) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (strb_i) begin
          shift = 1'b1;
          if (last_c) begin
            shadow_we  = 1'b1;
            state_next = ADDR;
          end
        end
      end
      DISCARD: begin
        if (exit_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow bank: holds the last completed write per address across windows.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_COEF; i++) shadow_coef[i] <= '0;
      shadow_period <= PERIOD_W'(PERIOD_RST);
      shadow_min    <= MIN_W'(MIN_RST);
    end else if (shadow_we) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if ({1'b0, addr_q} == 4'(i)) shadow_coef[i] <= value_c[REG_BITWIDTH-1:0];
      end
      if ({1'b0, addr_q} == ADDR_PERIOD) shadow_period <= value_c[PERIOD_W-1:0];
      if ({1'b0, addr_q} == ADDR_MIN)    shadow_min    <= value_c[MIN_W-1:0];
    end
  end

  // Active bank: only changes as a whole, so FanCTRL never sees a torn set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_COEF; i++) active_coef[i] <= '0;
      period_q <= PERIOD_W'(PERIOD_RST);
      min_q    <= MIN_W'(MIN_RST);
    end else if (apply) begin
      for (int i = 0; i < NUM_COEF; i++) active_coef[i] <= shadow_coef[i];
      period_q <= shadow_period;
      min_q    <= shadow_min;
    end
  end

  assign a0_o         = active_coef[0];
  assign a1_o         = active_coef[1];
  assign b0_o         = active_coef[2];
  assign b1_o         = active_coef[3];
  assign b2_o         = active_coef[4];
  assign pwm_period_o = period_q;
  assign pwm_min_o    = min_q;
  assign busy_o       = busy_q;
  assign applied_o    = applied_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fanctrl_cfg_loader.sv
// Self-checking bench for fanctrl_cfg_loader: directed scenarios plus random
// windows checked against a frame-level register model.
module tb_fanctrl_cfg_loader;

  localparam int unsigned RW = 32;
  localparam int unsigned AW = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          config_en_i;
  logic          strb_i;
  logic [3:0]    data_i;
  logic [RW-1:0] a0_o, a1_o, b0_o, b1_o, b2_o;
  logic [AW:0]   pwm_period_o;
  logic [AW-1:0] pwm_min_o;
  logic          busy_o, applied_o, err_o;

  int errors = 0;
  int checks = 0;

  // Model: index 0..4 coefficients, 5 period, 6 min.
  logic [31:0] m_shadow [7];
  logic [31:0] m_active [7];
  logic        m_err, m_discard, m_partial;

  fanctrl_cfg_loader dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .config_en_i  (config_en_i),
    .strb_i       (strb_i),
    .data_i       (data_i),
    .a0_o         (a0_o),
    .a1_o         (a1_o),
    .b0_o         (b0_o),
    .b1_o         (b1_o),
    .b2_o         (b2_o),
    .pwm_period_o (pwm_period_o),
    .pwm_min_o    (pwm_min_o),
    .busy_o       (busy_o),
    .applied_o    (applied_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 7; i++) begin
      m_shadow[i] = (i == 5) ? 32'd399 : 32'd0;
      m_active[i] = m_shadow[i];
    end
    m_err = 1'b0; m_discard = 1'b0; m_partial = 1'b0;
  endtask

  function automatic int frame_len(input logic [3:0] addr);
    if (addr == 4'd5) return 3;
    if (addr == 4'd6) return 2;
    return 8;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ":a0"},     a0_o,               m_active[0]);
    check({tag, ":a1"},     a1_o,               m_active[1]);
    check({tag, ":b0"},     b0_o,               m_active[2]);
    check({tag, ":b1"},     b1_o,               m_active[3]);
    check({tag, ":b2"},     b2_o,               m_active[4]);
    check({tag, ":period"}, 32'(pwm_period_o),  m_active[5]);
    check({tag, ":min"},    32'(pwm_min_o),     m_active[6]);
    check({tag, ":err"},    32'(err_o),         32'(m_err));
    check({tag, ":busy"},   32'(busy_o),        32'd0);
  endtask

  task automatic nib(input logic [3:0] d);
    @(negedge clk_i);
    strb_i = 1'b1; data_i = d;
    @(negedge clk_i);
    strb_i = 1'b0; data_i = 4'($urandom);
    repeat ($urandom_range(0, 1)) @(negedge clk_i);
  endtask

  task automatic win_open(input string tag);
    @(negedge clk_i);
    config_en_i = 1'b1;
    m_discard = 1'b0; m_partial = 1'b0;
    @(negedge clk_i);
    m_err = 1'b0;
    check({tag, ":open_err"}, 32'(err_o), 32'(m_err));
  endtask

  // Sends an address nibble plus nsend payload nibbles of val, MSB first.
  task automatic send_frame(input logic [3:0] addr, input logic [31:0] val, input int nsend);
    int n;
    n = (addr > 4'd6) ? nsend : frame_len(addr);
    nib(addr);
    for (int k = 0; k < nsend; k++) nib(val[4*(n-1-k) +: 4]);
    if (!m_discard) begin
      if (addr > 4'd6) begin
        m_err = 1'b1; m_discard = 1'b1;
      end else if (nsend < n) begin
        m_partial = 1'b1;
      end else if (addr == 4'd5) begin
        m_shadow[5] = val & 32'h1FF;
      end else if (addr == 4'd6) begin
        m_shadow[6] = val & 32'hFF;
      end else begin
        m_shadow[addr] = val;
      end
    end
  endtask

  task automatic win_close(input string tag, input bit strobe_on_exit);
    logic exp_apply;
    @(negedge clk_i);
    config_en_i = 1'b0;
    if (strobe_on_exit) begin strb_i = 1'b1; data_i = 4'($urandom); end
    exp_apply = !m_discard && !m_partial && !m_err;
    if (m_partial && !m_discard) m_err = 1'b1;
    if (exp_apply) for (int i = 0; i < 7; i++) m_active[i] = m_shadow[i];
    @(negedge clk_i);
    strb_i = 1'b0;
    check({tag, ":applied"}, 32'(applied_o), 32'(exp_apply));
    check_outputs(tag);
    @(negedge clk_i);
    check({tag, ":applied_end"}, 32'(applied_o), 32'd0);
  endtask

  initial begin
    logic [3:0]  addr;
    logic [31:0] val;
    int          nf, nsend;

    rstn_i = 1'b0; config_en_i = 1'b0; strb_i = 1'b0; data_i = 4'd0;
    m_reset();
    #12;
    check_outputs("reset");
    check("reset:applied", 32'(applied_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Coefficient a0 and PWM min in one window.
    win_open("t2");
    send_frame(4'd0, 32'h4000_0000, 8);
    send_frame(4'd6, 32'h0000_0032, 2);
    win_close("t2", 1'b0);
    check("t2:a0_const", a0_o, 32'h4000_0000);
    check("t2:min_const", 32'(pwm_min_o), 32'h32);

    // Period keeps only its low 9 bits; a0 untouched.
    win_open("t3");
    send_frame(4'd5, 32'h0000_0FFF, 3);
    win_close("t3", 1'b0);
    check("t3:period_const", 32'(pwm_period_o), 32'h1FF);
    check("t3:a0_const", a0_o, 32'h4000_0000);

    // Invalid address discards the window; next window clears err.
    win_open("t4");
    send_frame(4'd9, 32'h0000_0ABC, 3);
    win_close("t4", 1'b0);
    check("t4:err_const", 32'(err_o), 32'd1);
    win_open("t4b");
    win_close("t4b", 1'b0);

    // Partial frame at exit.
    win_open("t5");
    send_frame(4'd2, $urandom, 3);
    check("t5:busy_mid", 32'(busy_o), 32'd1);
    win_close("t5", 1'b0);
    check("t5:err_const", 32'(err_o), 32'd1);

    // Asynchronous reset in the middle of a payload.
    win_open("t6");
    send_frame(4'd0, $urandom, 2);
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0; config_en_i = 1'b0; strb_i = 1'b0;
    #1;
    m_reset();
    check_outputs("t6_rst");
    check("t6_rst:applied", 32'(applied_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    win_open("t6b");
    send_frame(4'd1, $urandom, 8);
    win_close("t6b", 1'b0);

    // Random windows.
    for (int w = 0; w < 16; w++) begin
      win_open("rnd");
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 9) == 0) begin
          addr  = 4'($urandom_range(7, 15));
          nsend = $urandom_range(0, 3);
        end else begin
          addr  = 4'($urandom_range(0, 6));
          nsend = frame_len(addr);
          if (f == nf - 1 && $urandom_range(0, 4) == 0) nsend = $urandom_range(0, frame_len(addr) - 1);
        end
        val = $urandom;
        send_frame(addr, val, nsend);
      end
      win_close("rnd", bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        nib(4'($urandom)); nib(4'($urandom));
        @(negedge clk_i);
        check_outputs("stray");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
